// File: rtl/hpi_pkg.sv
// Shared constants for the HPI responder: register map, STATUS bit layout and
// pointer step.
package hpi_pkg;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int ST_MBX_OUT = 0;
    localparam int ST_MBX_IN  = 1;
    localparam int ST_OVR     = 2;

    localparam logic [15:0] PTR_STEP = 16'd2;

    function automatic logic [15:0] status_word(input logic ovr, input logic mbx_in,
                                                input logic mbx_out);
        logic [15:0] w;
        w             = '0;
        w[ST_OVR]     = ovr;
        w[ST_MBX_IN]  = mbx_in;
        w[ST_MBX_OUT] = mbx_out;
        return w;
    endfunction

endpackage

// File: rtl/hpi_responder_if.sv
// HPI pins between an initiator (SoC PIO exports) and the responder.
interface hpi_responder_if;
    logic        reset_n;
    logic [1:0]  address;
    logic        cs_n;
    logic        r_n;
    logic        w_n;
    logic [15:0] data_in;
    logic [15:0] data_out;

    modport master (output reset_n, address, cs_n, r_n, w_n, data_in, input data_out);
    modport slave  (input reset_n, address, cs_n, r_n, w_n, data_in, output data_out);
endinterface

// File: rtl/hpi_dpram.sv
// True dual-port word RAM, synchronous read-before-write, no reset.
// Port A wins a same-word, same-cycle write collision.
module hpi_dpram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [15:0]       wdata_a,
    output logic [15:0]       rdata_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [15:0]       wdata_b,
    output logic [15:0]       rdata_b
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_b && !(we_a && (addr_a == addr_b))) begin
            mem[addr_b] <= wdata_b;
        end
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
    end
endmodule

// File: rtl/hpi_responder.sv
// HPI target: DATA/MAILBOX/ADDRESS/STATUS register map over a local word memory,
// with a device-side memory port and inbound/outbound mailboxes.
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    hpi_responder_if.slave    hpi,
    input  logic [ADDR_W-1:0] lcl_addr,
    input  logic              lcl_we,
    input  logic [15:0]       lcl_wdata,
    output logic [15:0]       lcl_rdata,
    input  logic              lcl_mbx_we,
    input  logic [15:0]       lcl_mbx_wdata,
    output logic [15:0]       mbx_in_data,
    output logic              mbx_in_valid,
    input  logic              mbx_in_ack,
    output logic              irq
);
    logic        rst;
    logic        wr_ev, rd_start, rd_end, hpi_mem_we;
    logic [15:0] ram_a_rdata, ram_b_rdata;

    logic        r_q, r_d, w_q, w_d;
    logic        rd_active_q, rd_active_d;
    logic        rd_load_q, rd_load_d;
    logic [1:0]  rd_reg_q, rd_reg_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] data_out_q, data_out_d;
    logic [15:0] mbx_in_data_q, mbx_in_data_d;
    logic        mbx_in_valid_q, mbx_in_valid_d;
    logic        ovr_q, ovr_d;
    logic [15:0] mbx_out_q, mbx_out_d;
    logic        mbx_out_flag_q, mbx_out_flag_d;
    logic        lcl_ok_q, lcl_ok_d;

    assign rst = reset_reset | ~hpi.reset_n;

    // Strobe history resets to "asserted" so a strobe held across reset is not an edge.
    assign wr_ev      = ~hpi.cs_n & ~hpi.w_n & w_q;
    assign rd_start   = ~hpi.cs_n & ~hpi.r_n & r_q & hpi.w_n;
    assign rd_end     = hpi.r_n & rd_active_q;
    assign hpi_mem_we = wr_ev && (hpi.address == HPI_DATA);

    hpi_dpram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk_clk),
        .we_a    (hpi_mem_we),
        .addr_a  (ptr_q[ADDR_W:1]),
        .wdata_a (hpi.data_in),
        .rdata_a (ram_a_rdata),
        .we_b    (lcl_we),
        .addr_b  (lcl_addr),
        .wdata_b (lcl_wdata),
        .rdata_b (ram_b_rdata)
    );

    always_comb begin
        r_d            = hpi.r_n;
        w_d            = hpi.w_n;
        rd_active_d    = rd_active_q;
        rd_load_d      = rd_start;
        rd_reg_d       = rd_reg_q;
        ptr_d          = ptr_q;
        data_out_d     = data_out_q;
        mbx_in_data_d  = mbx_in_data_q;
        mbx_in_valid_d = mbx_in_valid_q;
        ovr_d          = ovr_q;
        mbx_out_d      = mbx_out_q;
        mbx_out_flag_d = mbx_out_flag_q;
        lcl_ok_d       = 1'b1;

        if (rd_start) begin
            rd_active_d = 1'b1;
            rd_reg_d    = hpi.address;
        end else if (rd_end) begin
            rd_active_d = 1'b0;
        end

        // RAM port A was addressed on the start edge, so its data is ready one edge later.
        if (rd_load_q) begin
            case (rd_reg_q)
                HPI_DATA:    data_out_d = ram_a_rdata;
                HPI_MAILBOX: data_out_d = mbx_out_q;
                HPI_ADDRESS: data_out_d = ptr_q;
                default:     data_out_d = status_word(ovr_q, mbx_in_valid_q, mbx_out_flag_q);
            endcase
        end

        if (rd_end && (rd_reg_q == HPI_DATA)) begin
            ptr_d = ptr_q + PTR_STEP;
        end

        if (mbx_in_ack) begin
            mbx_in_valid_d = 1'b0;
        end

        if (lcl_mbx_we) begin
            mbx_out_d      = lcl_mbx_wdata;
            mbx_out_flag_d = 1'b1;
        end else if (rd_end && (rd_reg_q == HPI_MAILBOX)) begin
            mbx_out_flag_d = 1'b0;
        end

        if (wr_ev) begin
            case (hpi.address)
                HPI_DATA:    ptr_d = ptr_q + PTR_STEP;
                HPI_MAILBOX: begin
                    mbx_in_data_d  = hpi.data_in;
                    mbx_in_valid_d = 1'b1;
                    if (mbx_in_valid_q && !mbx_in_ack) begin
                        ovr_d = 1'b1;
                    end
                end
                HPI_ADDRESS: ptr_d = hpi.data_in;
                default: begin
                    if (hpi.data_in[ST_OVR]) begin
                        ovr_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (rst) begin
            r_q            <= 1'b0;
            w_q            <= 1'b0;
            rd_active_q    <= 1'b0;
            rd_load_q      <= 1'b0;
            rd_reg_q       <= HPI_DATA;
            ptr_q          <= '0;
            data_out_q     <= '0;
            mbx_in_data_q  <= '0;
            mbx_in_valid_q <= 1'b0;
            ovr_q          <= 1'b0;
            mbx_out_q      <= '0;
            mbx_out_flag_q <= 1'b0;
            lcl_ok_q       <= 1'b0;
        end else begin
            r_q            <= r_d;
            w_q            <= w_d;
            rd_active_q    <= rd_active_d;
            rd_load_q      <= rd_load_d;
            rd_reg_q       <= rd_reg_d;
            ptr_q          <= ptr_d;
            data_out_q     <= data_out_d;
            mbx_in_data_q  <= mbx_in_data_d;
            mbx_in_valid_q <= mbx_in_valid_d;
            ovr_q          <= ovr_d;
            mbx_out_q      <= mbx_out_d;
            mbx_out_flag_q <= mbx_out_flag_d;
            lcl_ok_q       <= lcl_ok_d;
        end
    end

    assign hpi.data_out = data_out_q;
    assign lcl_rdata    = lcl_ok_q ? ram_b_rdata : 16'h0000;
    assign mbx_in_data  = mbx_in_data_q;
    assign mbx_in_valid = mbx_in_valid_q;
    assign irq          = mbx_out_flag_q;
endmodule

// File: doc/hpi_responder.md
Name: hpi_responder

Overview:
- Synthesizable target (responder) end of the OTG HPI port driven by the SoC PIO exports (address[1:0], cs, r, w, reset, 16-bit data in/out).
- Implements the four-register HPI map: DATA, MAILBOX, ADDRESS, STATUS.
- Backed by a local word memory and two mailboxes, so the HPI driver can be run on-chip or in loopback without the USB controller.
- Includes a local device-side port for memory and mailbox access.

Parameters:
- ADDR_W, 12, word-address width of local memory; DEPTH = 2**ADDR_W 16-bit words.

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- hpi_reset_n  in  1  initiator soft reset; low has the same effect as reset_reset
- hpi_address  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
- hpi_cs_n  in  1  chip select, active low
- hpi_r_n  in  1  read strobe, active low
- hpi_w_n  in  1  write strobe, active low
- hpi_data_in  in  16  write data from initiator
- hpi_data_out  out  16  read data to initiator
- lcl_addr  in  ADDR_W  local memory word address
- lcl_we  in  1  local memory write enable
- lcl_wdata  in  16  local write data
- lcl_rdata  out  16  local read data; 1-cycle latency
- lcl_mbx_we  in  1  load outbound mailbox
- lcl_mbx_wdata  in  16  outbound mailbox value
- mbx_in_data  out  16  last host-written mailbox value
- mbx_in_valid  out  1  inbound mailbox pending
- mbx_in_ack  in  1  clears mbx_in_valid
- irq  out  1  outbound mailbox full, awaiting host read

Behaviour:
- Reset (reset_reset or hpi_reset_n low, sampled at the clock edge):
  - Outputs hpi_data_out, lcl_rdata, mbx_in_data, mbx_in_valid and irq are 0.
  - ptr = 0, all flags = 0.
  - Memory contents are not reset.
  - Strobe history r_q/w_q resets to 0 ("already asserted"), and rd_active resets to 0, so a strobe held through reset release is ignored.
- Write event: cs_n=0, w_n=0, w_q=1 (falling edge). Address and data are sampled that cycle; the action commits at that edge.
- Read start: cs_n=0, r_n=0, r_q=1.
  - Sets rd_active.
  - hpi_data_out is updated by the 2nd rising edge after the start sample, then held until the next read start.
  - The initiator holds r_n low ≥3 cycles.
- Read end: r_n rises while rd_active. Clears rd_active and applies read side effects. cs_n is not required at read end.
- r_n and w_n both low: the write is honoured, the read is ignored, and hpi_data_out is unchanged.
- ptr: 16-bit byte address; word index = ptr[ADDR_W:1]; bit 0 ignored.
- DATA (0):
  - Write stores mem[idx] and sets ptr += 2 at the same edge.
  - Read returns mem[idx]; ptr += 2 at read end.
  - ptr wraps 0xFFFE -> 0x0000; idx wraps modulo DEPTH.
- MAILBOX (1):
  - Write: mbx_in_data <= data, mbx_in_valid <= 1.
  - If valid was already 1 and not acked that cycle, set ovr (sticky).
  - Write coinciding with mbx_in_ack: write wins, valid stays 1, no ovr.
  - Read: returns mbx_out; at read end, irq/mbx_out_flag clears.
  - lcl_mbx_we loads mbx_out and sets the flag; set wins over a simultaneous read-end clear.
- ADDRESS (2): write ptr <= data; read returns ptr.
- STATUS (3):
  - Read returns {13'b0, ovr, mbx_in_valid, mbx_out_flag} (bit0 = outbound full, bit1 = inbound pending, bit2 = overrun).
  - Write: bit2 = 1 clears ovr (W1C); other bits are ignored.
- irq = mbx_out_flag (registered).
- Memory is dual-port: HPI port and local port.
  - Same-word, same-cycle writes: the HPI write wins and the local write is dropped.
  - A local read of a word written the same cycle returns old data.

Decomposition:
- Package hpi_pkg:
  - Register indices: HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDRESS=2'd2, HPI_STATUS=2'd3.
  - STATUS bit positions: ST_MBX_OUT=0, ST_MBX_IN=1, ST_OVR=2.
  - PTR_STEP=16'd2.
- One sub-module, hpi_dpram: true dual-port RAM with synchronous read and no reset, used for both ports.
- Strobe edge detection, ptr, mailboxes and STATUS stay in hpi_responder.

Test Plan:
- Write ADDRESS 0x0100, then DATA 0x1234 and DATA 0x5678 -> lcl read of word 0x080 = 0x1234 and 0x081 = 0x5678; HPI read of ADDRESS = 0x0104.
- After the first scenario, write ADDRESS 0x0100 and read DATA twice -> 0x1234 then 0x5678; ADDRESS = 0x0104; hpi_data_out stable between strobes.
- Host writes MAILBOX 0xBEEF -> mbx_in_valid=1, mbx_in_data=0xBEEF. Write 0xCAFE with no ack -> STATUS read = 0x0006. Write STATUS 0x0004 -> STATUS = 0x0002. Pulse mbx_in_ack -> STATUS = 0x0000.
- lcl_mbx_we with 0x00A5 -> irq=1, STATUS = 0x0001. Host MAILBOX read returns 0x00A5; irq drops one cycle after r_n rises. Repeat with lcl_mbx_we on the read-end cycle -> irq stays 1.
- Write ADDRESS 0xFFFE, then DATA 0x1111 -> ADDRESS reads 0x0000; lcl read of word 0xFFF = 0x1111. Same-cycle HPI and lcl writes to one word (0x2222 vs 0x3333) -> word = 0x2222.
- Pull hpi_reset_n low mid DATA read strobe, release with r_n still low, then raise r_n -> all outputs 0, ptr stays 0, no increment. Both strobes low with DATA 0x4444 -> write only, hpi_data_out unchanged.
